mux_sipo_deser: RTL and testbench

//  Serial-in/parallel-out deserializer built from 2:1-mux D-flop cells. It sits directly

---
 rtl/mux_sipo_deser_pkg.sv | 13 +
 rtl/mux_dff_cell.sv | 26 ++
 rtl/mux_sipo_deser.sv | 127 ++++++++++++
 tb/tb_mux_sipo_deser.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_sipo_deser_pkg.sv
// Shared types and defaults for the mux-cell SIPO deserializer.
// Output-port FSM states plus default geometry.
package mux_sipo_deser_pkg;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } out_state_t;

   localparam int DEF_WIDTH     = 8;
   localparam bit DEF_MSB_FIRST = 1'b1;

endpackage

// File: rtl/mux_dff_cell.sv
// Storage cell: hold/load mux feeding a D flop with a synchronous clear mux.
// Latency one edge; no flow control of its own (i_en is the only qualifier).
module mux_dff_cell (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_en,
   input  logic i_d,
   output logic o_q
);

   logic r_q;
   logic w_hold_mux;

   assign w_hold_mux = i_en ? i_d : r_q;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_q <= 1'b0;
      end else begin
         r_q <= w_hold_mux;
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/mux_sipo_deser.sv
// Serial-in/parallel-out deserializer: word valid the cycle after its last bit edge.
// Words completing while the output is full and not accepted are dropped with a one-cycle overrun pulse.
module mux_sipo_deser
   import mux_sipo_deser_pkg::*;
#(
   parameter int WIDTH     = DEF_WIDTH,
   parameter bit MSB_FIRST = DEF_MSB_FIRST
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_ser_in,
   input  logic                     i_ser_en,
   input  logic                     i_ser_sync,
   output logic [WIDTH-1:0]         o_out_data,
   output logic                     o_out_valid,
   input  logic                     i_out_ready,
   output logic [$clog2(WIDTH)-1:0] o_bit_cnt,
   output logic                     o_overrun
);

   localparam int               CNT_W    = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

   logic [WIDTH-1:0] w_sr_q;
   logic [WIDTH-1:0] w_sr_d;
   logic [WIDTH-1:0] w_word;
   logic [WIDTH-1:0] w_out_q;
   logic             w_complete;
   logic             w_load;
   logic             w_drop;

   logic [CNT_W-1:0] r_bit_cnt;
   out_state_t       r_state;
   logic             r_out_valid;
   logic             r_overrun;

   // A realign bit never completes a word, even when the counter sits at the last slot.
   assign w_complete = i_ser_en & ~i_ser_sync & (r_bit_cnt == LAST_CNT);

   generate
      if (MSB_FIRST) begin : g_msb_first
         logic w_unused_sr_top;
         assign w_unused_sr_top = w_sr_q[WIDTH-1];
         assign w_word = {w_sr_q[WIDTH-2:0], i_ser_in};
         assign w_sr_d = i_ser_sync ? {{(WIDTH-1){1'b0}}, i_ser_in} : w_word;
      end else begin : g_lsb_first
         logic w_unused_sr_bot;
         assign w_unused_sr_bot = w_sr_q[0];
         assign w_word = {i_ser_in, w_sr_q[WIDTH-1:1]};
         assign w_sr_d = i_ser_sync ? {i_ser_in, {(WIDTH-1){1'b0}}} : w_word;
      end
   endgenerate

   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_cells
         mux_dff_cell u_sr_cell (
            .i_clk (i_clk),
            .i_rst (i_rst),
            .i_en  (i_ser_en),
            .i_d   (w_sr_d[gi]),
            .o_q   (w_sr_q[gi])
         );

         mux_dff_cell u_out_cell (
            .i_clk (i_clk),
            .i_rst (i_rst),
            .i_en  (w_load),
            .i_d   (w_word[gi]),
            .o_q   (w_out_q[gi])
         );
      end
   endgenerate

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_bit_cnt <= '0;
      end else if (i_ser_en) begin
         if (i_ser_sync) begin
            r_bit_cnt <= ONE_CNT;
         end else if (w_complete) begin
            r_bit_cnt <= '0;
         end else begin
            r_bit_cnt <= r_bit_cnt + ONE_CNT;
         end
      end
   end

   // Loading while full is only legal when the held word leaves on the same edge.
   assign w_load = w_complete & ((r_state == ST_EMPTY) | i_out_ready);
   assign w_drop = w_complete & (r_state == ST_FULL) & ~i_out_ready;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= ST_EMPTY;
         r_out_valid <= 1'b0;
         r_overrun   <= 1'b0;
      end else begin
         r_overrun <= w_drop;
         case (r_state)
            ST_EMPTY: begin
               if (w_complete) begin
                  r_state     <= ST_FULL;
                  r_out_valid <= 1'b1;
               end
            end
            ST_FULL: begin
               if (i_out_ready & ~w_complete) begin
                  r_state     <= ST_EMPTY;
                  r_out_valid <= 1'b0;
               end
            end
            default: begin
               r_state     <= ST_EMPTY;
               r_out_valid <= 1'b0;
            end
         endcase
      end
   end

   assign o_out_data  = w_out_q;
   assign o_out_valid = r_out_valid;
   assign o_bit_cnt   = r_bit_cnt;
   assign o_overrun   = r_overrun;

endmodule

// File: tb/tb_mux_sipo_deser.sv
// Bench for mux_sipo_deser: directed cases plus random traffic against a queue-based model.
// A negedge monitor compares both bit orders and pops delivered words from a scoreboard.
module tb_mux_sipo_deser;

   localparam int W = 8;

   logic         clk;
   logic         rst;
   logic         ser_in;
   logic         ser_en;
   logic         ser_sync;
   logic         out_ready;
   logic [W-1:0] d1_data;
   logic [W-1:0] d0_data;
   logic         d1_valid;
   logic         d0_valid;
   logic         d1_ovr;
   logic         d0_ovr;
   logic [2:0]   d1_cnt;
   logic [2:0]   d0_cnt;

   // Reference model state
   logic         m_bits[$];
   logic [W-1:0] exp_q[$];
   bit           m_pend;
   logic [W-1:0] m_last;
   bit           m_ovr;
   bit           mon_en;

   int total;
   int bad;

   mux_sipo_deser #(.WIDTH(W), .MSB_FIRST(1'b1)) u_dut_msb (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_ser_in    (ser_in),
      .i_ser_en    (ser_en),
      .i_ser_sync  (ser_sync),
      .o_out_data  (d1_data),
      .o_out_valid (d1_valid),
      .i_out_ready (out_ready),
      .o_bit_cnt   (d1_cnt),
      .o_overrun   (d1_ovr)
   );

   mux_sipo_deser #(.WIDTH(W), .MSB_FIRST(1'b0)) u_dut_lsb (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_ser_in    (ser_in),
      .i_ser_en    (ser_en),
      .i_ser_sync  (ser_sync),
      .o_out_data  (d0_data),
      .o_out_valid (d0_valid),
      .i_out_ready (out_ready),
      .o_bit_cnt   (d0_cnt),
      .o_overrun   (d0_ovr)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [W-1:0] rev_bits(input logic [W-1:0] v);
      logic [W-1:0] r;
      for (int i = 0; i < W; i++) r[i] = v[W-1-i];
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: bits collected as a list; a word is their binary value, first bit most significant.
   task automatic model_edge();
      int  acc;
      bit  comp;
      if (rst) begin
         m_bits.delete();
         exp_q.delete();
         m_pend = 0;
         m_last = '0;
         m_ovr  = 0;
      end else begin
         comp = 0;
         acc  = 0;
         if (ser_en) begin
            if (ser_sync) m_bits.delete();
            m_bits.push_back(ser_in);
            if (m_bits.size() == W) begin
               for (int i = 0; i < W; i++) acc = acc + (int'(m_bits[i]) << (W - 1 - i));
               m_bits.delete();
               comp = 1;
            end
         end
         m_ovr = 0;
         if (comp) begin
            if (!m_pend || out_ready) begin
               exp_q.push_back(W'(acc));
               m_last = W'(acc);
               m_pend = 1;
            end else begin
               m_ovr = 1;
            end
         end else if (m_pend && out_ready) begin
            m_pend = 0;
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic drive(input logic en, input logic b, input logic sy, input logic rd, input logic rs);
      ser_en    = en;
      ser_in    = b;
      ser_sync  = sy;
      out_ready = rd;
      rst       = rs;
      step();
   endtask

   task automatic send_word(input logic [W-1:0] w, input logic rd, input logic rd_last,
                            input int gap, input logic sync_first);
      for (int i = 0; i < W; i++) begin
         drive(1'b1, w[W-1-i], (i == 0) && sync_first, (i == W-1) ? rd_last : rd, 1'b0);
         if (i < W-1) begin
            for (int g = 0; g < gap; g++) begin
               drive(1'b0, 1'b0, 1'b0, rd, 1'b0);
               chk("gap_bit_cnt", d1_cnt, i + 1);
            end
         end
      end
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         chk("valid", d1_valid, m_pend);
         chk("data", d1_data, m_last);
         chk("overrun", d1_ovr, m_ovr);
         chk("bit_cnt", d1_cnt, m_bits.size());
         chk("lsb_valid", d0_valid, m_pend);
         chk("lsb_data", d0_data, rev_bits(m_last));
         chk("lsb_overrun", d0_ovr, m_ovr);
         chk("lsb_bit_cnt", d0_cnt, m_bits.size());
         if (d1_valid && out_ready && !rst) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL sb_underflow: word %0h delivered with none expected", d1_data);
            end else begin
               chk("sb_word", d1_data, exp_q[0]);
               void'(exp_q.pop_front());
            end
         end
      end
   end

   initial begin
      total  = 0;
      bad    = 0;
      mon_en = 0;
      m_pend = 0;
      m_last = '0;
      m_ovr  = 0;

      // Reset and idle
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      mon_en = 1;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("rst_valid", d1_valid, 0);
      chk("rst_data", d1_data, 8'h00);
      chk("rst_bit_cnt", d1_cnt, 0);
      chk("rst_overrun", d1_ovr, 0);

      // Back-to-back bits, consumer ready
      send_word(8'hB2, 1'b1, 1'b1, 0, 1'b0);
      chk("t2_data", d1_data, 8'hB2);
      chk("t2_lsb_data", d0_data, 8'h4D);
      chk("t2_valid", d1_valid, 1);
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("t2_valid_drop", d1_valid, 0);

      // One idle cycle between bits
      send_word(8'hB2, 1'b1, 1'b1, 1, 1'b0);
      chk("t3_data", d1_data, 8'hB2);
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

      // Backpressure: second word dropped
      send_word(8'hA5, 1'b0, 1'b0, 0, 1'b0);
      send_word(8'h3C, 1'b0, 1'b0, 0, 1'b0);
      chk("t4_data", d1_data, 8'hA5);
      chk("t4_valid", d1_valid, 1);
      chk("t4_overrun", d1_ovr, 1);
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("t4_valid_after_ready", d1_valid, 0);
      chk("t4_overrun_clear", d1_ovr, 0);

      // Accept and complete on the same edge
      send_word(8'hA5, 1'b0, 1'b0, 0, 1'b0);
      send_word(8'h3C, 1'b0, 1'b1, 0, 1'b0);
      chk("t5_data", d1_data, 8'h3C);
      chk("t5_valid", d1_valid, 1);
      chk("t5_overrun", d1_ovr, 0);
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

      // Realign after a partial word
      for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      chk("t6_partial_cnt", d1_cnt, 3);
      send_word(8'h5A, 1'b1, 1'b1, 0, 1'b1);
      chk("t6_sync_data", d1_data, 8'h5A);
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

      // Reset mid-word
      for (int i = 0; i < 4; i++) drive(1'b1, 1'(i != 1), 1'b0, 1'b1, 1'b0);
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      chk("t6_rst_cnt", d1_cnt, 0);
      send_word(8'hFF, 1'b1, 1'b1, 0, 1'b0);
      chk("t6_rst_data", d1_data, 8'hFF);
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

      // Random traffic
      for (int n = 0; n < 3000; n++) begin
         drive(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 249) == 0));
      end

      // Drain
      for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("drain_pending", exp_q.size(), 0);

      mon_en = 0;
      @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
